sprite_sequencer: RTL and testbench
===================================

Name: sprite_sequencer

Overview:
- Parametrised successor to the fixed three-pose boxer animator.
- Sweeps a WIDTH x HEIGHT sprite window pixel by pixel and drives ROM addresses plus a frame select. Delivers x/y/plot to vga_adapter, aligned to ROM read latency.
- Holds each frame for a programmable time, then advances through NUM_FRAMES frames in one-shot, loop or ping-pong order.
- Sits between the frame ROMs/colour mux and vga_adapter, replacing the hand-coded control/datapath pair.

Parameters:
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- ADDR_W, 16, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- IMG_W, 320, sprite width in pixels
- IMG_H, 165, sprite height in pixels
- X0, 0, screen x of sprite top-left
- Y0, 75, screen y of sprite top-left
- NUM_FRAMES, 3, frame count; legal range 1..2^FS_W
- FS_W, 2, frame_sel width
- HOLD_CYCLES, 100000000, clk cycles each frame is held after drawing; >=1
- HOLD_W, 28, hold counter width
- ROM_LATENCY, 1, ROM read latency in clk cycles; >=0

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- start  in  1  level; begins a sequence from IDLE
- stop  in  1  level; aborts immediately to IDLE
- mode  in  2  00 one-shot, 01 loop, 10 ping-pong, 11 treated as 01; sampled only on the start cycle
- rom_addr  out  ADDR_W  pixel address, row*IMG_W+col
- frame_sel  out  FS_W  current frame index, steers the ROM colour mux
- x  out  X_W  X0+col, delayed ROM_LATENCY cycles
- y  out  Y_W  Y0+row, delayed ROM_LATENCY cycles
- plot  out  1  write strobe, delayed ROM_LATENCY cycles
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse on the last HOLD cycle of each frame
- seq_done  out  1  one-cycle pulse on the transition to IDLE at the end of a one-shot sequence

Behaviour:
- Reset (async, resetn=0):
  - state IDLE; all counters and outputs 0.
  - Delay pipeline cleared; plot=0.
- State machine: IDLE, DRAW, HOLD, NEXT.
- IDLE:
  - start=1 and stop=0 → DRAW next cycle.
  - Latch mode; frame_sel=0; col=row=0; direction=up.
- DRAW: one pixel per cycle.
  - Undelayed plot=1, rom_addr = current address.
  - col increments; at col=IMG_W-1, col→0 and row increments.
  - Address counter increments by 1, with no multiplier.
  - After pixel (IMG_W-1, IMG_H-1) → HOLD.
  - DRAW lasts exactly IMG_W*IMG_H cycles.
- HOLD:
  - Undelayed plot=0; counts exactly HOLD_CYCLES cycles.
  - frame_done pulses in the final cycle; then → NEXT.
- NEXT: lasts 1 cycle with plot=0; col, row and address are reset to 0.
  - One-shot: if frame_sel=NUM_FRAMES-1 → IDLE with seq_done pulse; else frame_sel+1 → DRAW.
  - Loop: frame_sel wraps NUM_FRAMES-1 → 0 → DRAW.
  - Ping-pong: step by ±1 and reverse direction at 0 and NUM_FRAMES-1, giving 0,1,..,N-1,N-2,..,1,0,1,...
  - Ping-pong with NUM_FRAMES=1: frame stays 0.
- Latency and alignment:
  - x, y and plot come from a ROM_LATENCY-deep shift register fed by (X0+col, Y0+row, draw_active).
  - ROM_LATENCY=0 means a direct combinational path.
  - rom_addr and frame_sel are not delayed.
  - The final DRAW pixel's plot emerges ROM_LATENCY cycles into HOLD.
- stop:
  - Highest priority after reset, in any state → IDLE next cycle.
  - Delay pipeline plot bits are cleared on the same edge, so no stale pixel is written.
  - No seq_done pulse.
- start while busy is ignored.
- start and stop both high in IDLE: remain in IDLE.
- Output coordinates never exceed X0+IMG_W-1 / Y0+IMG_H-1.
- Coordinate arithmetic truncates to X_W/Y_W.
- The address counter never wraps within a frame, given the ADDR_W rule.

Test Plan:
Common bench parameters: IMG_W=4, IMG_H=2, X0=10, Y0=5, NUM_FRAMES=3, HOLD_CYCLES=5, ROM_LATENCY=1.
1. Reset mid-DRAW (resetn low 1 cycle) → same cycle: busy=0, plot=0, rom_addr=0, frame_sel=0.
2. One-shot start pulse → rom_addr 0..7 on consecutive cycles; plot high 8 cycles starting 1 cycle later; x=10..13, y=5,6. frame_done every 14 cycles (8+5+1). frame_sel 0,1,2, then seq_done and busy=0.
3. Loop mode, 5 frames observed → frame_sel 0,1,2,0,1; busy stays 1; no seq_done.
4. Ping-pong mode, 7 frames observed → frame_sel 0,1,2,1,0,1,2.
5. stop asserted on the 3rd DRAW cycle of frame 1 → next cycle busy=0, plot=0 (delayed pixel suppressed), no seq_done. A following start restarts at frame 0, pixel 0.
6. start held high throughout a one-shot sequence → the sequence does not restart mid-run; a new sequence begins on the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/sprite_sequencer.sv
// sprite_sequencer
//   Sweeps an IMG_W x IMG_H sprite window one pixel per clock, driving the
//   frame ROM address and frame select, and hands x/y/plot to vga_adapter
//   delayed so that they line up with the ROM read data. Each frame is held
//   for HOLD_CYCLES clocks after drawing. The sequencer then steps through
//   NUM_FRAMES frames in one-shot, loop or ping-pong order.
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   start      level, starts a sequence when idle
//   stop       level, aborts to idle on the next edge
//   mode       00 one-shot, 01 loop, 10 ping-pong, 11 loop (sampled on start)
//   rom_addr   pixel address row*IMG_W+col (undelayed)
//   frame_sel  current frame index (undelayed)
//   x, y       screen coordinates, delayed ROM_LATENCY cycles
//   plot       write strobe, delayed ROM_LATENCY cycles
//   busy       high whenever not idle
//   frame_done pulse in the last hold cycle of each frame
//   seq_done   pulse when a one-shot sequence returns to idle
module sprite_sequencer #(
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int ADDR_W      = 16,
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 165,
    parameter int X0          = 0,
    parameter int Y0          = 75,
    parameter int NUM_FRAMES  = 3,
    parameter int FS_W        = 2,
    parameter int HOLD_CYCLES = 100000000,
    parameter int HOLD_W      = 28,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [FS_W-1:0]   frame_sel,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic              plot,
    output logic              busy,
    output logic              frame_done,
    output logic              seq_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [FS_W-1:0]   FRAME_LAST = FS_W'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_HOLD, S_NEXT} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [FS_W-1:0]    frame_q, frame_d;
    logic               dir_down_q, dir_down_d;
    logic [1:0]         mode_q, mode_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic               draw_active;
    logic [X_W-1:0]     x_raw;
    logic [Y_W-1:0]     y_raw;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            frame_q    <= '0;
            dir_down_q <= 1'b0;
            mode_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            frame_q    <= frame_d;
            dir_down_q <= dir_down_d;
            mode_q     <= mode_d;
            hold_q     <= hold_d;
        end
    end

    // The address runs as its own counter alongside col/row, so no
    // row*IMG_W multiplier is needed. stop overrides every state.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        frame_d    = frame_q;
        dir_down_d = dir_down_q;
        mode_d     = mode_q;
        hold_d     = hold_q;
        seq_done   = 1'b0;
        frame_done = (state_q == S_HOLD) && (hold_q == HOLD_LAST);

        if (stop) begin
            state_d    = S_IDLE;
            col_d      = '0;
            row_d      = '0;
            addr_d     = '0;
            frame_d    = '0;
            dir_down_d = 1'b0;
            hold_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    col_d      = '0;
                    row_d      = '0;
                    addr_d     = '0;
                    frame_d    = '0;
                    dir_down_d = 1'b0;
                    hold_d     = '0;
                    if (start) begin
                        mode_d  = mode;
                        state_d = S_DRAW;
                    end
                end
                S_DRAW: begin
                    hold_d = '0;
                    if (col_q == COL_LAST && row_q == ROW_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = S_NEXT;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    state_d = S_DRAW;
                    if (mode_q == MODE_ONESHOT) begin
                        if (frame_q == FRAME_LAST) begin
                            state_d  = S_IDLE;
                            frame_d  = '0;
                            seq_done = 1'b1;
                        end else begin
                            frame_d = frame_q + 1'b1;
                        end
                    end else if (mode_q == MODE_PINGPONG) begin
                        // Turn around at either end so the end frames are
                        // shown once per pass rather than twice.
                        if (NUM_FRAMES == 1) begin
                            frame_d = '0;
                        end else if (!dir_down_q) begin
                            if (frame_q == FRAME_LAST) begin
                                frame_d    = frame_q - 1'b1;
                                dir_down_d = 1'b1;
                            end else begin
                                frame_d = frame_q + 1'b1;
                            end
                        end else begin
                            if (frame_q == '0) begin
                                frame_d    = frame_q + 1'b1;
                                dir_down_d = 1'b0;
                            end else begin
                                frame_d = frame_q - 1'b1;
                            end
                        end
                    end else begin
                        frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rom_addr    = addr_q;
    assign frame_sel   = frame_q;
    assign busy        = (state_q != S_IDLE);
    assign draw_active = (state_q == S_DRAW);
    assign x_raw       = X_W'(X0) + X_W'(col_q);
    assign y_raw       = Y_W'(Y0) + Y_W'(row_q);

    // x/y/plot travel through a shift register matching the ROM read
    // latency so the strobe meets the colour it belongs to.
    if (ROM_LATENCY == 0) begin : g_direct
        assign x    = x_raw;
        assign y    = y_raw;
        assign plot = draw_active;
    end else begin : g_pipe
        logic [X_W-1:0] x_pipe_q [ROM_LATENCY];
        logic [X_W-1:0] x_pipe_d [ROM_LATENCY];
        logic [Y_W-1:0] y_pipe_q [ROM_LATENCY];
        logic [Y_W-1:0] y_pipe_d [ROM_LATENCY];
        logic           plot_pipe_q [ROM_LATENCY];
        logic           plot_pipe_d [ROM_LATENCY];

        // On stop every in-flight strobe is dropped so no stale pixel
        // reaches the frame buffer after the abort.
        always_comb begin
            x_pipe_d[0]    = x_raw;
            y_pipe_d[0]    = y_raw;
            plot_pipe_d[0] = draw_active && !stop;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                x_pipe_d[i]    = x_pipe_q[i-1];
                y_pipe_d[i]    = y_pipe_q[i-1];
                plot_pipe_d[i] = plot_pipe_q[i-1] && !stop;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < ROM_LATENCY; i++) begin
                    x_pipe_q[i]    <= '0;
                    y_pipe_q[i]    <= '0;
                    plot_pipe_q[i] <= 1'b0;
                end
            end else begin
                for (int i = 0; i < ROM_LATENCY; i++) begin
                    x_pipe_q[i]    <= x_pipe_d[i];
                    y_pipe_q[i]    <= y_pipe_d[i];
                    plot_pipe_q[i] <= plot_pipe_d[i];
                end
            end
        end

        assign x    = x_pipe_q[ROM_LATENCY-1];
        assign y    = y_pipe_q[ROM_LATENCY-1];
        assign plot = plot_pipe_q[ROM_LATENCY-1];
    end

endmodule

// File: tb/tb_sprite_sequencer.sv
// tb_sprite_sequencer
//   Scoreboard bench for sprite_sequencer on a small 4x2 sprite. The driver
//   issues sequences (directed and random) cycle by cycle and pushes the
//   expected pixels, frame_done and seq_done events, each tagged with its
//   cycle number. A monitor on the falling edge pops and compares them
//   whenever the DUT strobes plot, frame_done or seq_done.
module tb_sprite_sequencer;

    localparam int X_W         = 9;
    localparam int Y_W         = 8;
    localparam int ADDR_W      = 16;
    localparam int IMG_W       = 4;
    localparam int IMG_H       = 2;
    localparam int X0          = 10;
    localparam int Y0          = 5;
    localparam int NUM_FRAMES  = 3;
    localparam int FS_W        = 2;
    localparam int HOLD_CYCLES = 5;
    localparam int HOLD_W      = 28;
    localparam int ROM_LATENCY = 1;

    localparam int PIXELS   = IMG_W * IMG_H;
    localparam int PERIOD   = PIXELS + HOLD_CYCLES + 1;
    localparam int SEQ_LEN  = NUM_FRAMES * PERIOD;
    localparam int INF      = 32'h3fff_ffff;

    localparam int K_NONE = 0;
    localparam int K_STOP = 1;
    localparam int K_RST  = 2;

    typedef struct {
        int cyc;
        int x;
        int y;
        int f;
        int addr;
    } pix_t;

    typedef struct {
        int cyc;
        int f;
    } evt_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] rom_addr;
    logic [FS_W-1:0]   frame_sel;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              plot;
    logic              busy;
    logic              frame_done;
    logic              seq_done;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   prev_addr = 0;

    pix_t pix_q[$];
    evt_t fd_q[$];
    int   seq_q[$];

    sprite_sequencer #(
        .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .X0(X0), .Y0(Y0), .NUM_FRAMES(NUM_FRAMES), .FS_W(FS_W),
        .HOLD_CYCLES(HOLD_CYCLES), .HOLD_W(HOLD_W), .ROM_LATENCY(ROM_LATENCY)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .mode(mode),
        .rom_addr(rom_addr), .frame_sel(frame_sel), .x(x), .y(y),
        .plot(plot), .busy(busy), .frame_done(frame_done), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Frame shown in the k-th displayed frame slot of a sequence.
    function automatic int frame_of(input logic [1:0] m, input int k);
        int p;
        if (m == 2'b00) return k;
        if (m == 2'b10) begin
            if (NUM_FRAMES == 1) return 0;
            p = k % (2 * NUM_FRAMES - 2);
            return (p < NUM_FRAMES) ? p : 2 * NUM_FRAMES - 2 - p;
        end
        return k % NUM_FRAMES;
    endfunction

    // A sequence started with start high during cycle base draws pixel p of
    // slot k in cycle base+1+k*PERIOD+p; its strobe appears ROM_LATENCY later.
    task automatic push_expect(input int base, input logic [1:0] m,
                               input int plot_lim, input int seq_lim);
        int   kmax;
        int   pc;
        int   fc;
        pix_t pe;
        evt_t ee;
        kmax = (m == 2'b00) ? NUM_FRAMES : 1000;
        for (int k = 0; k < kmax; k++) begin
            if (base + 1 + k * PERIOD >= plot_lim) break;
            for (int p = 0; p < PIXELS; p++) begin
                pc = base + 1 + k * PERIOD + p + ROM_LATENCY;
                if (pc < plot_lim) begin
                    pe.cyc  = pc;
                    pe.x    = X0 + p % IMG_W;
                    pe.y    = Y0 + p / IMG_W;
                    pe.f    = frame_of(m, k);
                    pe.addr = p;
                    pix_q.push_back(pe);
                end
            end
            fc = base + k * PERIOD + PIXELS + HOLD_CYCLES;
            if (fc < plot_lim) begin
                ee.cyc = fc;
                ee.f   = frame_of(m, k);
                fd_q.push_back(ee);
            end
        end
        if (m == 2'b00 && base + SEQ_LEN < seq_lim) seq_q.push_back(base + SEQ_LEN);
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one sequence. kind selects how it ends: naturally (one-shot),
    // by stop or by reset in cycle base+abort_off. With hold_start the start
    // line stays high through a one-shot run, and the automatic second run
    // is then ended by kind/abort_off.
    task automatic applyStimulus(input logic [1:0] m, input int kind,
                                 input int abort_off, input bit hold_start);
        int base;
        int run_base;
        int abort_abs;
        int plot_lim;
        int seq_lim;
        base = cyc;
        if (hold_start) begin
            push_expect(base, 2'b00, INF, INF);
            run_base = base + SEQ_LEN + 1;
        end else begin
            run_base = base;
        end
        abort_abs = (kind == K_NONE) ? run_base + SEQ_LEN + 1 : run_base + abort_off;
        plot_lim  = (kind == K_STOP) ? abort_abs + 1 : (kind == K_RST) ? abort_abs : INF;
        seq_lim   = (kind == K_NONE) ? INF : abort_abs;
        push_expect(run_base, hold_start ? 2'b00 : m, plot_lim, seq_lim);

        start = 1'b1;
        mode  = hold_start ? 2'b00 : m;
        step_cycle();
        if (!hold_start) begin
            start = 1'b0;
            mode  = 2'($urandom);
        end
        while (cyc < abort_abs) begin
            if (hold_start && cyc == base + SEQ_LEN + 1)
                checkOutput("hold_idle_busy", busy, 0);
            if (hold_start && cyc == base + SEQ_LEN + 2) begin
                checkOutput("hold_restart_busy", busy, 1);
                start = 1'b0;
                mode  = 2'($urandom);
            end
            step_cycle();
        end

        if (kind == K_STOP) begin
            stop = 1'b1;
            step_cycle();
            stop = 1'b0;
            checkOutput("stop_busy", busy, 0);
            checkOutput("stop_plot", plot, 0);
        end else if (kind == K_RST) begin
            resetn = 1'b0;
            #1;
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_plot", plot, 0);
            checkOutput("rst_rom_addr", rom_addr, 0);
            checkOutput("rst_frame_sel", frame_sel, 0);
            @(posedge clk);
            #1;
            resetn = 1'b1;
        end else begin
            checkOutput("end_busy", busy, 0);
        end
        step_cycle();
    endtask

    // Monitor: every strobe must match the next expected event, on the
    // expected cycle. rom_addr is compared one cycle before its plot.
    always @(negedge clk) begin
        pix_t pe;
        evt_t ee;
        int   se;
        if (plot) begin
            if (pix_q.size() == 0) begin
                checkOutput("plot_unexpected", plot, 0);
            end else begin
                pe = pix_q.pop_front();
                checkOutput("pix_cycle", cyc, pe.cyc);
                checkOutput("pix_x", x, pe.x);
                checkOutput("pix_y", y, pe.y);
                checkOutput("pix_frame", frame_sel, pe.f);
                checkOutput("pix_addr", prev_addr, pe.addr);
            end
        end
        if (frame_done) begin
            if (fd_q.size() == 0) begin
                checkOutput("frame_done_unexpected", frame_done, 0);
            end else begin
                ee = fd_q.pop_front();
                checkOutput("frame_done_cycle", cyc, ee.cyc);
                checkOutput("frame_done_frame", frame_sel, ee.f);
            end
        end
        if (seq_done) begin
            if (seq_q.size() == 0) begin
                checkOutput("seq_done_unexpected", seq_done, 0);
            end else begin
                se = seq_q.pop_front();
                checkOutput("seq_done_cycle", cyc, se);
            end
        end
        prev_addr = rom_addr;
    end

    initial begin
        int m;
        int kind;
        int off;
        resetn = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 2'b00;
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_plot", plot, 0);
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_frame_sel", frame_sel, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        step_cycle();

        $display("[TB] directed sequences");
        applyStimulus(2'b00, K_NONE, 0, 1'b0);
        applyStimulus(2'b01, K_STOP, PIXELS + HOLD_CYCLES + 4 * PERIOD, 1'b0);
        applyStimulus(2'b10, K_STOP, PIXELS + HOLD_CYCLES + 6 * PERIOD, 1'b0);
        applyStimulus(2'b00, K_STOP, PERIOD + 3, 1'b0);
        applyStimulus(2'b00, K_NONE, 0, 1'b0);
        applyStimulus(2'b11, K_RST, 4, 1'b0);
        applyStimulus(2'b00, K_STOP, 20, 1'b1);

        start = 1'b1;
        stop  = 1'b1;
        step_cycle();
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("start_stop_busy", busy, 0);
        step_cycle();
        checkOutput("start_stop_plot", plot, 0);

        $display("[TB] random sequences");
        for (int i = 0; i < 16; i++) begin
            m    = $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            if (m != 0 && kind == K_NONE) kind = K_STOP;
            off  = (m == 0) ? $urandom_range(1, SEQ_LEN + 1) : $urandom_range(1, 80);
            applyStimulus(2'(m), kind, off, 1'b0);
        end
        applyStimulus(2'b00, K_STOP, $urandom_range(2, 40), 1'b1);

        repeat (3) step_cycle();
        checkOutput("pix_left", pix_q.size(), 0);
        checkOutput("frame_done_left", fd_q.size(), 0);
        checkOutput("seq_done_left", seq_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
